// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB phases
// on a shared ALU/memory datapath, with an optional multi-cycle MUL stall.
module multicycle_control_fsm #(
    parameter int unsigned ALUC_W     = 4,
    parameter int unsigned RD_W       = 4,
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [RD_W-1:0]   Rd,
    input  logic              CondEx,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemW,
    output logic              RegW,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [1:0]        FlagW,
    output logic              InstrDone
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StMulWait,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluMul = 4'b0010;
    localparam logic [3:0] AluBrd = 4'b0011;
    localparam logic [3:0] AluAnd = 4'b0100;
    localparam logic [3:0] AluOrr = 4'b0101;
    localparam logic [3:0] AluPrd = 4'b0110;
    localparam logic [3:0] AluMov = 4'b1000;
    localparam logic [3:0] AluStp = 4'b1100;
    localparam logic [3:0] AluCme = 4'b1101;

    // MULWAIT runs MUL_CYCLES-1 cycles; the counter reaches zero on the last one.
    localparam bit          MulStall = (MUL_CYCLES > 1);
    localparam int unsigned MulLoad  = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
    localparam logic [3:0]  CntLoad  = MulLoad[3:0];

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [3:0] dp_alu;
    logic       dp_valid;
    logic       dp_no_wr;
    logic       dp_s;
    logic       dp_is_mul;
    logic       mul_stall;
    logic       dp_wr_ok;
    logic [1:0] flag_upd;
    logic       rd_pc;
    logic [1:0] reg_src;
    logic [3:0] alu_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data-processing decode of Funct[4:1]; unknown codes fall back to ADD with no writes.
    always_comb begin
        dp_alu   = AluAdd;
        dp_valid = 1'b1;
        dp_no_wr = 1'b0;
        case (Funct[4:1])
            4'b0000: dp_alu = AluAdd;
            4'b0001: dp_alu = AluSub;
            4'b0010: dp_alu = AluMul;
            4'b0011: dp_alu = AluMov;
            4'b1000: dp_alu = AluAnd;
            4'b1001: dp_alu = AluOrr;
            4'b1010: dp_alu = AluPrd;
            4'b1011: dp_alu = AluBrd;
            4'b0100: begin
                dp_alu   = AluSub;
                dp_no_wr = 1'b1;
            end
            4'b1100: dp_alu = AluStp;
            4'b1101: begin
                dp_alu   = AluCme;
                dp_no_wr = 1'b1;
            end
            4'b1111: dp_alu = AluMov;
            default: begin
                dp_alu   = AluAdd;
                dp_valid = 1'b0;
            end
        endcase
    end

    assign dp_s      = Funct[0];
    assign dp_is_mul = (Funct[4:1] == 4'b0010);
    assign mul_stall = MulStall & dp_is_mul;
    assign dp_wr_ok  = CondEx & dp_valid & ~dp_no_wr;
    assign rd_pc     = &Rd;
    assign flag_upd  = {2{CondEx & dp_valid}}
                     & {dp_s, dp_s & ((dp_alu == AluAdd) | (dp_alu == AluSub))};

    always_comb begin
        if (Op == 2'b01 && !Funct[0]) begin
            reg_src = 2'b10;
        end else if (Op == 2'b10) begin
            reg_src = 2'b01;
        end else begin
            reg_src = 2'b00;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemW      = 1'b0;
        RegW      = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ImmSrc    = Op;
        RegSrc    = reg_src;
        alu_ctrl  = AluAdd;
        FlagW     = 2'b00;
        InstrDone = 1'b0;

        unique case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    2'b11:   state_d = StExecI;
                    default: state_d = Funct[5] ? StExecI : StExecR;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegW      = CondEx;
                PCWrite   = CondEx & rd_pc;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            StMemWr: begin
                AdrSrc    = 1'b1;
                MemW      = CondEx;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            StExecR, StExecI: begin
                ALUSrcB  = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_ctrl = dp_alu;
                if (mul_stall) begin
                    state_d = StMulWait;
                    cnt_d   = CntLoad;
                end else begin
                    FlagW   = flag_upd;
                    state_d = StAluWb;
                end
            end
            StMulWait: begin
                alu_ctrl = AluMul;
                if (cnt_q == 4'd0) begin
                    FlagW   = flag_upd;
                    state_d = StAluWb;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAluWb: begin
                RegW      = dp_wr_ok;
                PCWrite   = dp_wr_ok & rd_pc;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = CondEx;
                InstrDone = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset abandons any in-flight instruction without a single write.
        if (reset) begin
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            MemW      = 1'b0;
            RegW      = 1'b0;
            FlagW     = 2'b00;
            InstrDone = 1'b0;
            state_d   = StFetch;
            cnt_d     = 4'd0;
        end
    end

    assign ALUControl = ALUC_W'(alu_ctrl);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: a per-instruction cycle plan is built from the instruction rules,
// queued as expected control words, and compared by an independent negedge monitor.
module tb_multicycle_control_fsm;

    localparam int unsigned MC = 3;

    typedef struct packed {
        logic       ir;
        logic       pc;
        logic       adr;
        logic       memw;
        logic       regw;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [3:0] aluc;
        logic [1:0] flagw;
        logic       done;
    } ctl_t;

    typedef struct packed {
        ctl_t        exp;
        ctl_t        mask;
        int unsigned tag;
        int unsigned cyc;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic       CondEx = 1'b0;
    logic       IRWrite, PCWrite, AdrSrc, MemW, RegW, ALUSrcA, InstrDone;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [3:0] ALUControl;

    sb_t  sb_q[$];
    ctl_t plan[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   instr_id = 0;

    multicycle_control_fsm #(
        .ALUC_W    (4),
        .RD_W      (4),
        .MUL_CYCLES(MC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .CondEx    (CondEx),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemW      (MemW),
        .RegW      (RegW),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl),
        .FlagW     (FlagW),
        .InstrDone (InstrDone)
    );

    always #5 clk = ~clk;

    function automatic ctl_t enable_mask();
        ctl_t m;
        m       = '0;
        m.ir    = 1'b1;
        m.pc    = 1'b1;
        m.memw  = 1'b1;
        m.regw  = 1'b1;
        m.flagw = 2'b11;
        m.done  = 1'b1;
        return m;
    endfunction

    function automatic void alu_lookup(input logic [3:0] cmd, output logic [3:0] aluc,
                                       output logic ok, output logic nowr);
        ok   = 1'b1;
        nowr = 1'b0;
        case (cmd)
            4'b0000: aluc = 4'b0000;
            4'b0001: aluc = 4'b0001;
            4'b0010: aluc = 4'b0010;
            4'b0011: aluc = 4'b1000;
            4'b1000: aluc = 4'b0100;
            4'b1001: aluc = 4'b0101;
            4'b1010: aluc = 4'b0110;
            4'b1011: aluc = 4'b0011;
            4'b0100: begin aluc = 4'b0001; nowr = 1'b1; end
            4'b1100: aluc = 4'b1100;
            4'b1101: begin aluc = 4'b1101; nowr = 1'b1; end
            4'b1111: aluc = 4'b1000;
            default: begin aluc = 4'b0000; ok = 1'b0; end
        endcase
    endfunction

    // Reference: the list of control words one instruction must produce, cycle by cycle.
    task automatic build_plan(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                              input logic c);
        ctl_t       base, w;
        logic [3:0] aluc;
        logic       ok, nowr, s, pcdst;
        logic [1:0] fl;
        int         waits;
        plan.delete();
        base        = '0;
        base.imm    = op;
        base.regsrc = (op == 2'b01 && !fn[0]) ? 2'b10 : (op == 2'b10) ? 2'b01 : 2'b00;
        pcdst       = (rd == 4'hF);
        w = base; w.ir = 1'b1; w.pc = 1'b1; w.srca = 1'b1; w.srcb = 2'b10; w.res = 2'b10;
        plan.push_back(w);
        w = base; w.srca = 1'b1; w.srcb = 2'b10; w.res = 2'b10;
        plan.push_back(w);
        case (op)
            2'b01: begin
                w = base; w.srcb = 2'b01;
                plan.push_back(w);
                if (fn[0]) begin
                    w = base; w.adr = 1'b1;
                    plan.push_back(w);
                    w = base; w.res = 2'b01; w.regw = c; w.pc = c & pcdst; w.done = 1'b1;
                    plan.push_back(w);
                end else begin
                    w = base; w.adr = 1'b1; w.memw = c; w.done = 1'b1;
                    plan.push_back(w);
                end
            end
            2'b10: begin
                w = base; w.srcb = 2'b01; w.res = 2'b10; w.pc = c; w.done = 1'b1;
                plan.push_back(w);
            end
            default: begin
                alu_lookup(fn[4:1], aluc, ok, nowr);
                s     = fn[0];
                fl    = ok ? {s & c, s & c & (aluc == 4'b0000 || aluc == 4'b0001)} : 2'b00;
                waits = (fn[4:1] == 4'b0010 && MC > 1) ? int'(MC) - 1 : 0;
                w = base; w.srcb = (op == 2'b11 || fn[5]) ? 2'b01 : 2'b00; w.aluc = aluc;
                if (waits == 0) w.flagw = fl;
                plan.push_back(w);
                for (int i = 0; i < waits; i++) begin
                    w = base; w.aluc = 4'b0010;
                    if (i == waits - 1) w.flagw = fl;
                    plan.push_back(w);
                end
                w = base; w.regw = c & ok & ~nowr; w.pc = c & ok & ~nowr & pcdst; w.done = 1'b1;
                plan.push_back(w);
            end
        endcase
    endtask

    // Called at posedge+1 with the DUT in FETCH; abort_at >= 0 asserts reset in that cycle.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                             input logic c, input int abort_at);
        sb_t e;
        build_plan(op, fn, rd, c);
        Op = op; Funct = fn; Rd = rd; CondEx = c;
        for (int k = 0; k < plan.size(); k++) begin
            e.tag = instr_id;
            e.cyc = k;
            if (k == abort_at) begin
                reset  = 1'b1;
                e.exp  = '0;
                e.mask = enable_mask();
                sb_q.push_back(e);
                @(posedge clk);
                #1 reset = 1'b0;
                break;
            end
            e.exp  = plan[k];
            e.mask = '1;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        instr_id++;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            sb_t  e;
            ctl_t act;
            e   = sb_q.pop_front();
            act = {IRWrite, PCWrite, AdrSrc, MemW, RegW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                   RegSrc, ALUControl, FlagW, InstrDone};
            n_chk++;
            if (((act ^ e.exp) & e.mask) !== '0) begin
                $display("FAIL ctl instr %0d cyc %0d: got %b expected %b (mask %b)",
                         e.tag, e.cyc, act, e.exp, e.mask);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        sb_t e;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] rd;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e.tag  = 9999;
            e.cyc  = k;
            e.exp  = '0;
            e.mask = enable_mask();
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr(2'b01, 6'b011001, 4'd3,  1'b1, -1);  // LDR
        run_instr(2'b01, 6'b011000, 4'd2,  1'b0, -1);  // STR, condition failed
        run_instr(2'b01, 6'b011000, 4'd5,  1'b1, -1);  // STR
        run_instr(2'b00, 6'b000001, 4'hF,  1'b1, -1);  // ADDS to PC
        run_instr(2'b00, 6'b001001, 4'hF,  1'b1, -1);  // CMP
        run_instr(2'b00, 6'b000101, 4'd4,  1'b1, -1);  // MULS with stall
        run_instr(2'b00, 6'b000100, 4'hF,  1'b0, -1);  // MUL, condition failed
        run_instr(2'b10, 6'b000000, 4'd0,  1'b0, -1);  // B not taken
        run_instr(2'b10, 6'b100000, 4'd0,  1'b1, -1);  // B taken
        run_instr(2'b01, 6'b011001, 4'hF,  1'b1, 3);   // LDR reset in MEMRD
        run_instr(2'b01, 6'b011001, 4'hF,  1'b1, -1);  // LDR to PC
        run_instr(2'b00, 6'b001011, 4'hF,  1'b1, -1);  // undefined DP code
        run_instr(2'b11, 6'b000011, 4'd7,  1'b1, -1);  // SUBS ext-imm
        run_instr(2'b00, 6'b111011, 4'd1,  1'b1, -1);  // CME with S

        for (int n = 0; n < 80; n++) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom_range(0, 63));
            rd = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            run_instr(op, fn, rd, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
